// File: rtl/logic_analyzer_gen.sv
// Multi-channel logic-analyzer capture (edge/immediate trigger, single/continuous) and VGA trace renderer.
// Optional graticule in blue when the macro LA_GRID_EN is defined.
module logic_analyzer_gen #(
    parameter int CH    = 4,
    parameter int DEPTH = 80,
    parameter int DIV   = 125
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cont,
    input  logic [1:0]    trig_mode,
    input  logic [1:0]    trig_ch,
    input  logic [CH-1:0] in,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          video_on,
    output logic [2:0]    rgb,
    output logic          busy,
    output logic          done
);
    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [6:0]    COL_LAST = 7'(DEPTH - 1);
    localparam logic [2:0]    CH3      = 3'(CH);
`ifdef LA_GRID_EN
    localparam int XW = 6;
`else
    localparam int XW = 3;
`endif

    typedef enum logic [1:0] {IDLE, ARM, FIRST, SECOND} state_t;
    state_t state, state_nxt;

    logic [CH-1:0]    sync_q, s;
    logic [CW-1:0]    cnt;
    logic             tick;
    logic [6:0]       cursor;
    logic [DEPTH-1:0] valid;
    logic             primed, prev;
    logic [CH-1:0]    pair_hi;
    logic [3:0]       s4;
    logic [1:0]       tc;
    logic             trig_s, fire, we;
    logic [2*CH-1:0]  wr_data;
    logic [2*CH-1:0]  ram [0:127];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s      <= '0;
            cnt    <= '0;
        end else begin
            sync_q <= in;
            s      <= sync_q;
            cnt    <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = (cnt == '0);

    // Trigger source: out-of-range channel indices fall back to channel 0.
    always_comb begin
        s4          = '0;
        s4[CH-1:0]  = s;
        tc          = ({1'b0, trig_ch} < CH3) ? trig_ch : 2'd0;
        trig_s      = s4[tc];
        case (trig_mode)
            2'b00:   fire = 1'b1;
            2'b01:   fire = primed & ~prev & trig_s;
            2'b10:   fire = primed & prev & ~trig_s;
            default: fire = primed & (prev ^ trig_s);
        endcase
    end

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = ARM;
            ARM:    if (tick && fire) state_nxt = SECOND;
            FIRST:  if (tick) state_nxt = SECOND;
            SECOND: if (tick) begin
                we = 1'b1;
                if (cursor == COL_LAST) begin
                    done      = 1'b1;
                    state_nxt = cont ? ARM : IDLE;
                end else begin
                    state_nxt = FIRST;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cursor <= '0;
            valid  <= '0;
            primed <= 1'b0;
            prev   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                cursor <= '0;
                valid  <= '0;
                primed <= 1'b0;
            end
            if (state == ARM && tick) begin
                prev   <= trig_s;
                primed <= 1'b1;
            end
            if (we) begin
                valid[cursor] <= 1'b1;
                cursor        <= (cursor == COL_LAST) ? 7'd0 : cursor + 7'd1;
            end
            if (done) primed <= 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            wr_data[2*k+1] = pair_hi[k];
            wr_data[2*k]   = s[k];
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ARM && tick && fire) || (state == FIRST && tick)) pair_hi <= s;
        if (we) ram[cursor] <= wr_data;
    end

    // Stage p0: RAM read, coordinates and column-valid flag travel together.
    logic [2*CH-1:0] rd_p0;
    logic [XW-1:0]   x_p0;
    logic [9:0]      y_p0;
    logic            vld_p0, col_vld_p0;
    logic [127:0]    valid_ext;

    assign valid_ext = 128'(valid);  // columns >= DEPTH read as invalid

    always_ff @(posedge clk) begin
        rd_p0 <= ram[pixel_x[9:3]];
        x_p0  <= pixel_x[XW-1:0];
        y_p0  <= pixel_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0     <= 1'b0;
            col_vld_p0 <= 1'b0;
        end else begin
            vld_p0     <= video_on;
            col_vld_p0 <= valid_ext[pixel_x[9:3]];
        end
    end

    // Stage p1: trace/grid decision and registered colour.
    logic [7:0] rd8;
    logic [1:0] ch;
    logic [5:0] yy;
    logic [2:0] xx;
    logic       p1, p0, lvl, band_ok, trace;
    logic [2:0] rgb_nxt;

    always_comb begin
        rd8             = '0;
        rd8[2*CH-1:0]   = rd_p0;
        ch              = y_p0[8:7];
        yy              = y_p0[5:0];
        xx              = x_p0[2:0];
        p1              = rd8[{ch, 1'b1}];
        p0              = rd8[{ch, 1'b0}];
        lvl             = xx[2] ? p0 : p1;
        // Odd bands and y >= 448 (band 7 or y[9]) are blank.
        band_ok         = ~y_p0[9] & ~y_p0[6] & ({1'b0, ch} < CH3) & col_vld_p0;
        trace           = (lvl && yy == 6'd8) || (!lvl && yy == 6'd56) ||
                          (p1 != p0 && xx == 3'd4 && yy >= 6'd8 && yy <= 6'd56);
        rgb_nxt         = (band_ok && trace) ? 3'b010 : 3'b000;
`ifdef LA_GRID_EN
        if (band_ok && !trace && (x_p0[5:0] == 6'd0 || (yy == 6'd32 && !x_p0[1])))
            rgb_nxt = 3'b001;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) rgb <= 3'b000;
        else     rgb <= vld_p0 ? rgb_nxt : 3'b000;
    end
endmodule

// File: tb/tb_logic_analyzer_gen.sv
// Directed bench for logic_analyzer_gen (CH=4, DEPTH=80, DIV=4); activity on the falling clock edge.
module tb_logic_analyzer_gen;
    localparam int CH    = 4;
    localparam int DEPTH = 80;
    localparam int DIV   = 4;

    logic          clk = 1'b0;
    logic          rst, start, cont;
    logic [1:0]    trig_mode, trig_ch;
    logic [CH-1:0] in_sig;
    logic [9:0]    pixel_x, pixel_y;
    logic          video_on;
    logic [2:0]    rgb;
    logic          busy, done;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    always #5 clk = ~clk;

    logic_analyzer_gen #(.CH(CH), .DEPTH(DEPTH), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .trig_mode(trig_mode), .trig_ch(trig_ch), .in(in_sig),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .rgb(rgb), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    // Negedge k lies in the clock interval following reset-release edge E_k.
    task automatic reset_and_start();
        rst = 1'b1; start = 1'b0;
        step(); step();
        rst = 1'b0; start = 1'b1; k = 0;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(output int at);
        at = -1;
        while (k < 2000) begin
            if (done) begin
                at = k;
                break;
            end
            step();
        end
    endtask

    task automatic chk_px(input string tag, input int x, input int y, input bit vo, input int exp);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = vo;
        step(); step();
        check(tag, int'(rgb), exp);
    endtask

    int at, bad_busy, early, n_done, d1, d2, fall;

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; trig_mode = 2'b00; trig_ch = 2'd0;
        in_sig = '0; pixel_x = '0; pixel_y = 10'd8; video_on = 1'b1;
        step(); step();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rgb", int'(rgb), 0);

        // Immediate trigger, constant 0101
        in_sig = 4'b0101;
        reset_and_start();
        run_to_done(at);
        check("t1_done_at", at, 640);
        step();
        check("t1_done_pulse", int'(done), 0);
        check("t1_idle", int'(busy), 0);
        chk_px("t1_ch0_hi", 0, 8, 1'b1, 2);
        chk_px("t1_ch0_p0", 4, 8, 1'b1, 2);
        chk_px("t1_ch0_lo", 0, 56, 1'b1, 0);
        chk_px("t1_ch0_noedge", 4, 30, 1'b1, 0);
        chk_px("t1_ch1_lo", 0, 184, 1'b1, 2);
        chk_px("t1_ch1_hi", 0, 136, 1'b1, 0);
        chk_px("t1_ch2_hi", 0, 264, 1'b1, 2);
        chk_px("t1_ch3_lo", 0, 440, 1'b1, 2);
        chk_px("t1_last_col", 636, 8, 1'b1, 2);
        chk_px("t1_past_depth", 640, 8, 1'b1, 0);
        chk_px("t1_odd_band", 0, 72, 1'b1, 0);
        chk_px("t1_y_456", 0, 456, 1'b1, 0);
        chk_px("t1_y_520", 0, 520, 1'b1, 0);
        chk_px("t1_video_off", 0, 8, 1'b0, 0);
        chk_px("t1_video_back", 0, 8, 1'b1, 2);

        // Rising-edge trigger on ch2 after 10 low ticks
        trig_mode = 2'b01; trig_ch = 2'd2; in_sig = '0;
        pixel_x = 10'd0; pixel_y = 10'd264; video_on = 1'b1;
        reset_and_start();
        bad_busy = 0; early = 0;
        while (k < 60) begin
            if (k == 41) in_sig = 4'b0100;
            if (!busy) bad_busy++;
            if (k <= 50 && rgb != 3'b000) early++;
            if (k == 51) check("t2_col0_written", int'(rgb), 2);
            step();
        end
        check("t2_busy_thru", bad_busy, 0);
        check("t2_no_early_write", early, 0);
        check("t2_no_done", int'(done), 0);

        // Square wave at half the sample rate on ch0
        trig_mode = 2'b00; trig_ch = 2'd0; in_sig = '0;
        reset_and_start();
        at = -1;
        while (k < 2000) begin
            if (done) begin
                at = k;
                break;
            end
            if (k % 4 == 1) in_sig[0] = ~in_sig[0];
            step();
        end
        check("t3_done_at", at, 640);
        for (int c = 0; c < DEPTH; c++) begin
            chk_px($sformatf("t3_edge_c%0d", c), c*8 + 4, 30, 1'b1, 2);
            chk_px($sformatf("t3_p1_c%0d", c), c*8 + 1, 8, 1'b1, 2);
        end
        chk_px("t3_p0_low", 5, 56, 1'b1, 2);
        chk_px("t3_p0_not_hi", 5, 8, 1'b1, 0);

        // Continuous mode with an ignored second start
        in_sig = 4'b0101; cont = 1'b1;
        reset_and_start();
        n_done = 0; d1 = 0; d2 = 0; fall = 0;
        while (k < 1400) begin
            if (done) begin
                n_done++;
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
            end
            if (!busy && fall == 0) fall = k;
            if (k == 642) check("t4_busy_rearm", int'(busy), 1);
            if (k == 100) start = 1'b1;
            if (k == 101) start = 1'b0;
            if (k == 700) cont = 1'b0;
            step();
        end
        check("t4_n_done", n_done, 2);
        check("t4_done1", d1, 640);
        check("t4_done2", d2, 1280);
        check("t4_busy_fall", fall, 1281);

        // Reset mid-capture at cursor 40
        pixel_x = 10'd0; pixel_y = 10'd8; video_on = 1'b1;
        reset_and_start();
        while (k < 324) step();
        check("t5_pre_rst_px", int'(rgb), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_rgb", int'(rgb), 0);
        chk_px("t5_col0_blank", 0, 8, 1'b1, 0);
        chk_px("t5_col20_blank", 160, 8, 1'b1, 0);
        chk_px("t5_col39_ch2_blank", 312, 264, 1'b1, 0);
        chk_px("t5_grid_blank", 64, 20, 1'b1, 0);

        // Graticule after a completed capture
        reset_and_start();
        run_to_done(at);
        check("t6_done_at", at, 640);
`ifdef LA_GRID_EN
        chk_px("t6_grid_vline", 64, 20, 1'b1, 1);
        chk_px("t6_grid_dot", 65, 32, 1'b1, 1);
        chk_px("t6_grid_gap", 66, 32, 1'b1, 0);
`else
        chk_px("t6_nogrid_vline", 64, 20, 1'b1, 0);
        chk_px("t6_nogrid_dot", 65, 32, 1'b1, 0);
`endif
        chk_px("t6_trace_prio", 64, 8, 1'b1, 2);
        chk_px("t6_odd_band_plain", 64, 72, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
